// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Pairs with imem_loader.sv; IMEM_LOADER_CKSUM_EN selects the checksummed frame format.
package imem_loader_pkg;

  localparam int INSTR_W = 20;
  localparam int ADDR_W  = 8;

  localparam logic [7:0] DEFAULT_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_CKSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  // Big-endian assembly: only the low nibble of the first byte is meaningful.
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [7:0] b0,
                                                    input logic [7:0] b1,
                                                    input logic [7:0] b2);
    return {b0[3:0], b1, b2};
  endfunction

endpackage

// File: rtl/imem_loader_cksum.sv
// Running XOR over frame bytes; clear and accumulate may coincide to seed with the LEN byte.
// Instantiated by imem_loader only when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader_cksum (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       clear_i,
  input  logic       accum_i,
  input  logic [7:0] data_i,
  output logic       match_o
);

  logic [7:0] acc_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc_q <= 8'h00;
    end else if (clear_i || accum_i) begin
      acc_q <= (clear_i ? 8'h00 : acc_q) ^ (accum_i ? data_i : 8'h00);
    end
  end

  assign match_o = (acc_q == data_i);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing 20-bit instructions to instruction memory.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0]        HDR_BYTE  = DEFAULT_HDR,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic               clkwire,
  input  logic               rstwire,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_data,
  output logic               core_hold,
  output logic               load_done,
  output logic               load_err
);

  state_e               state_q, state_d;
  logic                 ready_q;
  logic [7:0]           rem_q, rem_d;
  logic [ADDR_W-1:0]    off_q, off_d;
  logic [7:0]           b0_q, b0_d;
  logic [7:0]           b1_q, b1_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   data_q, data_d;
  logic                 accept;

  assign accept = in_valid && ready_q;

`ifdef IMEM_LOADER_CKSUM_EN
  logic ck_clear, ck_accum, ck_match;

  assign ck_clear = accept && (state_q == ST_LEN);
  assign ck_accum = accept && (state_q inside {ST_LEN, ST_B0, ST_B1, ST_B2});

  imem_loader_cksum u_cksum (
    .clk_i   (clkwire),
    .srst_i  (rstwire),
    .clear_i (ck_clear),
    .accum_i (ck_accum),
    .data_i  (in_byte),
    .match_o (ck_match)
  );
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    off_d   = off_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (in_byte == HDR_BYTE) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (in_byte == 8'h00) begin
            state_d = ST_ERR;
          end else begin
            rem_d   = in_byte;
            off_d   = '0;
            state_d = ST_B0;
          end
        end
        ST_B0: begin
          if (in_byte[7:4] != 4'h0) begin
            state_d = ST_ERR;
          end else begin
            b0_d    = in_byte;
            state_d = ST_B1;
          end
        end
        ST_B1: begin
          b1_d    = in_byte;
          state_d = ST_B2;
        end
        ST_B2: begin
          // Address wraps modulo 256 by width truncation.
          we_d   = 1'b1;
          addr_d = BASE_ADDR + off_q;
          data_d = pack_instr(b0_q, b1_q, in_byte);
          off_d  = off_q + 8'd1;
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_B0;
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        ST_CKSUM: begin
          state_d = ck_match ? ST_DONE : ST_ERR;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkwire) begin
    if (rstwire) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rem_q   <= 8'h00;
      off_q   <= '0;
      b0_q    <= 8'h00;
      b1_q    <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      rem_q   <= rem_d;
      off_q   <= off_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Status flags decode straight from the registered state, so entering LEN clears them.
  assign in_ready  = ready_q;
  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_data = data_q;
  assign core_hold = (state_q != ST_DONE);
  assign load_done = (state_q == ST_DONE);
  assign load_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built at transaction level, expected writes
// are queued at stimulus time and a negedge monitor pops them on every imem_we.
module tb_imem_loader;

  localparam logic [7:0] HDR     = 8'hA5;
  localparam logic [7:0] TB_BASE = 8'hFC;

  typedef struct packed {
    logic [7:0]  addr;
    logic [19:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   gap_mode = 0;
  wr_t  exp_q[$];
  logic [7:0] pb0[256];
  logic [7:0] pb1[256];
  logic [7:0] pb2[256];

  imem_loader #(.HDR_BYTE(HDR), .BASE_ADDR(TB_BASE)) dut (
    .clkwire   (clk),
    .rstwire   (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(w.addr));
        check("write_data", 32'(imem_data), 32'(w.data));
        $display("write addr=%02h data=%05h", imem_addr, imem_data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int n;
    gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_byte  = HDR;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_err"},  32'(load_err),  32'(err));
    check({tag, "_core_hold"}, 32'(core_hold), 32'(!done));
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_imem_we",   32'(imem_we),   32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'(TB_BASE));
    check("rst_imem_data", 32'(imem_data), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err",  32'(load_err),  32'd0);
  endtask

  task automatic fill_rand(input int len, input int bad_idx);
    for (int k = 0; k < len; k++) begin
      pb0[k] = {4'h0, 4'($urandom)};
      if (k == bad_idx) pb0[k] = {4'($urandom_range(1, 15)), 4'($urandom)};
      pb1[k] = 8'($urandom);
      pb2[k] = 8'($urandom);
    end
  endtask

  // Reference: a frame writes instruction k to BASE+k until the first malformed B0.
  task automatic run_frame(input int len, input int bad_idx, input bit bad_ck);
    logic [7:0] x;
    int         nwr;
    bit         done;
    wr_t        last;
    nwr = (bad_idx >= 0) ? bad_idx : len;
    last = '0;
    for (int k = 0; k < nwr; k++) begin
      last.addr = TB_BASE + 8'(k);
      last.data = {pb0[k][3:0], pb1[k], pb2[k]};
      exp_q.push_back(last);
    end
    send_byte(HDR);
    check_status("hdr", 1'b0, 1'b0);
    send_byte(8'(len));
    x = 8'(len);
    if (len == 0) begin
      check_status("len0", 1'b0, 1'b1);
      return;
    end
    for (int k = 0; k < len; k++) begin
      send_byte(pb0[k]);
      x ^= pb0[k];
      if (k == bad_idx) begin
        check_status("bad_b0", 1'b0, 1'b1);
        return;
      end
      send_byte(pb1[k]);
      send_byte(pb2[k]);
      x ^= pb1[k] ^ pb2[k];
    end
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(bad_ck ? (x ^ 8'h5A) : x);
    done = !bad_ck;
`else
    done = 1'b1;
`endif
    check_status("frame_end", done, !done);
    if (nwr > 0) begin
      check("hold_addr", 32'(imem_addr), 32'(last.addr));
      check("hold_data", 32'(imem_data), 32'(last.data));
    end
  endtask

  task automatic load_plan_frame();
    pb0[0] = 8'h01; pb1[0] = 8'h23; pb2[0] = 8'h45;
    pb0[1] = 8'h0F; pb1[1] = 8'hFF; pb2[1] = 8'hFF;
    run_frame(2, -1, 1'b0);
  endtask

  initial begin
    int  len;
    int  bad;
    bit  bad_ck;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Plan frame, then the same after garbage bytes.
    load_plan_frame();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    check_status("garbage", 1'b1, 1'b0);
    load_plan_frame();

    // Illegal B0 high nibble; trailing bytes are discarded in ERR.
    pb0[0] = 8'h10; pb1[0] = 8'h00; pb2[0] = 8'h00;
    run_frame(1, 0, 1'b0);
    send_byte(8'h00);
    send_byte(8'h00);
    check_status("err_sticky", 1'b0, 1'b1);
    load_plan_frame();

`ifdef IMEM_LOADER_CKSUM_EN
    fill_rand(3, -1);
    run_frame(3, -1, 1'b1);
`endif

    // Stretched timing with in_valid toggling.
    gap_mode = 1;
    load_plan_frame();
    gap_mode = 0;

    // Reset after B1 of instruction 1: only instruction 0 is written.
    fill_rand(2, -1);
    exp_q.push_back('{addr: TB_BASE, data: {pb0[0][3:0], pb1[0], pb2[0]}});
    send_byte(HDR);
    send_byte(8'h02);
    send_byte(pb0[0]);
    send_byte(pb1[0]);
    send_byte(pb2[0]);
    send_byte(pb0[1]);
    send_byte(pb1[1]);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    load_plan_frame();

    // Randomized frames, including zero length, bad B0, wrap and one full-length frame.
    for (int it = 0; it < 24; it++) begin
      gap_mode = int'($urandom_range(0, 2));
      if (it == 10) len = 255;
      else if ($urandom_range(0, 9) == 0) len = 0;
      else len = int'($urandom_range(1, 12));
      bad = (len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      bad_ck = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == HDR) g = 8'h00;
        send_byte(g);
      end
      fill_rand(len, bad);
      run_frame(len, bad, bad_ck);
    end
    gap_mode = 0;

    repeat (5) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
